// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter behind the processor store port.
// Stores to TXDATA queue a byte in a small circular FIFO.
// Loads from STATUS return full/empty/busy/overflow/count for polling.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          DEPTH        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        io_sel,
    output logic [31:0] readdata,
    output logic        txd
);

    localparam int              PW          = $clog2(DEPTH);
    localparam int              CW          = PW + 1;
    localparam logic [CW-1:0]   FULL_CNT    = CW'(DEPTH);
    localparam logic [15:0]     BAUD_LAST   = 16'(CLKS_PER_BIT - 1);
    localparam logic [31:0]     STATUS_ADDR = BASE_ADDR + 32'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Registered state
    state_t          r_state;
    logic [7:0]      r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_ovf;
    logic [15:0]     r_baud;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic            r_txd;

    // Decode and next-state wires
    logic            w_sel_tx;
    logic            w_sel_st;
    logic            w_push;
    logic            w_ovf_set;
    logic            w_ovf_clr;
    logic            w_pop;
    logic            w_not_empty;
    logic            w_baud_end;
    logic [7:0]      w_head;
    logic [31:0]     w_status;
    state_t          w_state_nxt;
    logic [15:0]     w_baud_nxt;
    logic [2:0]      w_bitcnt_nxt;
    logic [7:0]      w_shift_nxt;
    logic            w_txd_nxt;
    logic            w_unused;

    // Only the low byte and the overflow-clear bit of the store data matter.
    assign w_unused    = ^writedata[31:8];

    assign w_sel_tx    = (dataadr == BASE_ADDR);
    assign w_sel_st    = (dataadr == STATUS_ADDR);
    assign io_sel      = w_sel_tx | w_sel_st;

    // The full check uses the registered count, so a same-cycle pop does not make room.
    assign w_push      = memwrite & w_sel_tx & (r_count != FULL_CNT);
    assign w_ovf_set   = memwrite & w_sel_tx & (r_count == FULL_CNT);
    assign w_ovf_clr   = memwrite & w_sel_st & writedata[3];

    assign w_not_empty = (r_count != '0);
    assign w_baud_end  = (r_baud == BAUD_LAST);
    assign w_head      = r_mem[r_rd_ptr];

    assign w_status    = {23'd0, 5'(r_count), r_ovf, (r_state != S_IDLE),
                          (r_count == '0), (r_count == FULL_CNT)};
    assign readdata    = w_sel_st ? w_status : 32'd0;
    assign txd         = r_txd;

    // Next-state logic for the serializer: start, 8 data bits LSB first, stop.
    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_txd_nxt    = r_txd;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_txd_nxt  = 1'b1;
                w_baud_nxt = '0;
                if (w_not_empty) begin
                    w_pop        = 1'b1;
                    w_shift_nxt  = w_head;
                    w_txd_nxt    = 1'b0;
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_txd_nxt   = r_shift[0];
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_bitcnt == 3'd7) begin
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_shift_nxt  = r_shift >> 1;
                        w_txd_nxt    = r_shift[1];
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (w_not_empty) begin
                        w_pop        = 1'b1;
                        w_shift_nxt  = w_head;
                        w_txd_nxt    = 1'b0;
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_txd_nxt   = 1'b1;
                w_baud_nxt  = '0;
            end
        endcase
    end

    // Serializer control registers; reset aborts any frame and drives the line idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_txd    <= 1'b1;
            r_baud   <= '0;
            r_bitcnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_txd    <= w_txd_nxt;
            r_baud   <= w_baud_nxt;
            r_bitcnt <= w_bitcnt_nxt;
        end
    end

    // Shift register holds only data; its value is don't-care until a pop loads it.
    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

    // FIFO pointers, occupancy and sticky overflow (set wins over clear).
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // FIFO storage; stale entries are harmless because the pointers are reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= writedata[7:0];
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized and directed stimulus for mmio_uart_tx, checked each
// cycle against a frame-timeline model plus a line decoder for literal byte checks.
module tb_mmio_uart_tx;

    localparam int          CPB  = 4;
    localparam int          DEP  = 4;
    localparam logic [31:0] TXA  = 32'hFFFF_FF00;
    localparam logic [31:0] STA  = 32'hFFFF_FF04;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        io_sel;
    logic [31:0] readdata;
    logic        txd;

    int n_checks = 0;
    int n_pass   = 0;

    mmio_uart_tx #(
        .BASE_ADDR   (TXA),
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .memwrite (memwrite),
        .dataadr  (dataadr),
        .writedata(writedata),
        .io_sel   (io_sel),
        .readdata (readdata),
        .txd      (txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model: byte queue + frame timeline ----------------
    logic [7:0] mq[$];
    bit         m_ovf = 0;
    bit         m_active = 0;
    int         m_t = 0;
    logic [7:0] m_cur = 8'h00;
    bit         mdl_started = 0;
    int         m_cnt;
    bit         m_push, m_set, m_clr, m_pop;

    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    always @(posedge clk) begin
        mdl_started = 1;
        if (!reset) begin
            mq.delete();
            m_ovf = 0;
            m_active = 0;
            m_t = 0;
        end else begin
            m_cnt  = mq.size();
            m_push = memwrite && (dataadr == TXA) && (m_cnt < DEP);
            m_set  = memwrite && (dataadr == TXA) && (m_cnt == DEP);
            m_clr  = memwrite && (dataadr == STA) && writedata[3];
            m_pop  = 0;
            if (!m_active) m_pop = (m_cnt > 0);
            else if (m_t == 10*CPB - 1) begin
                if (m_cnt > 0) m_pop = 1;
                else m_active = 0;
            end else m_t++;
            if (m_pop) begin
                m_cur = mq.pop_front();
                m_active = 1;
                m_t = 0;
            end
            if (m_push) mq.push_back(writedata[7:0]);
            if (m_clr) m_ovf = 0;
            if (m_set) m_ovf = 1;
        end
    end

    // ---------------- compare process ----------------
    logic        e_txd;
    logic [31:0] e_stat;
    always @(negedge clk) begin
        if (mdl_started) begin
            e_txd  = m_active ? fbit(m_cur, m_t / CPB) : 1'b1;
            e_stat = {23'd0, 5'(mq.size()), m_ovf, m_active, (mq.size() == 0), (mq.size() == DEP)};
            chk("txd", 32'(txd), 32'(e_txd));
            chk("io_sel", 32'(io_sel), 32'((dataadr == TXA) || (dataadr == STA)));
            chk("readdata", readdata, (dataadr == STA) ? e_stat : 32'd0);
        end
    end

    // ---------------- line decoder (samples mid-bit) ----------------
    logic [7:0] rxq[$];
    bit         rx_active = 0;
    int         rx_cyc = 0;
    int         rx_idx;
    logic [7:0] rx_sh = 8'h00;
    always @(negedge clk) begin
        if (reset !== 1'b1) rx_active = 0;
        else if (rx_active) begin
            rx_cyc++;
            if (rx_cyc % CPB == CPB/2) begin
                rx_idx = rx_cyc / CPB;
                if (rx_idx >= 1 && rx_idx <= 8) rx_sh[rx_idx-1] = txd;
                else if (rx_idx == 9) rxq.push_back(rx_sh);
            end
            if (rx_cyc == 10*CPB - 1) rx_active = 0;
        end else if (txd === 1'b0) begin
            rx_active = 1;
            rx_cyc = 0;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1;
        dataadr = a;
        writedata = d;
        tick();
        memwrite = 1'b0;
        dataadr = STA;
        writedata = 32'd0;
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        memwrite = 1'b0;
        dataadr = STA;
        #1;
        while (readdata[2:0] !== 3'b010 && n < 1000) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(readdata[2:0]), 32'h2);
    endtask

    logic [9:0]  pat1;
    logic [19:0] pat2;
    logic [7:0]  exp_b[$];
    logic [7:0]  b;
    int          bad;
    int          r;

    initial begin
        reset = 1'b0;
        memwrite = 1'b0;
        dataadr = STA;
        writedata = 32'd0;

        // Reset hold
        repeat (3) begin
            tick();
            chk("rst_txd", 32'(txd), 32'h1);
            chk("rst_status", readdata, 32'h2);
        end
        reset = 1'b1;
        tick();
        chk("post_rst_status", readdata, 32'h2);

        // Single byte A5
        rxq.delete();
        store(TXA, 32'h1234_56A5);
        chk("sb_txd_store_edge", 32'(txd), 32'h1);
        chk("sb_status_count1", readdata, 32'h10);
        pat1 = 10'b1101001010;
        bad = 0;
        tick();
        for (int k = 0; k < 40; k++) begin
            if (txd !== pat1[k/CPB]) bad++;
            if (k == 20) chk("sb_busy", 32'(readdata[2]), 32'h1);
            tick();
        end
        chk("sb_bits", bad, 0);
        chk("sb_txd_after", 32'(txd), 32'h1);
        chk("sb_status_after", readdata, 32'h2);
        chk("sb_rx_n", rxq.size(), 1);
        if (rxq.size() > 0) chk("sb_rx_byte", 32'(rxq[0]), 32'hA5);

        // Back-to-back 55, FF
        wait_idle();
        rxq.delete();
        store(TXA, 32'h55);
        store(TXA, 32'hFF);
        pat2 = {10'b1111111110, 10'b1010101010};
        bad = 0;
        for (int k = 0; k < 80; k++) begin
            if (txd !== pat2[k/CPB]) bad++;
            if (k == 20) chk("b2b_count1", 32'(readdata[8:4]), 32'h1);
            if (k == 60) chk("b2b_count0", 32'(readdata[8:4]), 32'h0);
            tick();
        end
        chk("b2b_bits", bad, 0);
        chk("b2b_rx_n", rxq.size(), 2);
        if (rxq.size() == 2) begin
            chk("b2b_rx0", 32'(rxq[0]), 32'h55);
            chk("b2b_rx1", 32'(rxq[1]), 32'hFF);
        end

        // Overflow
        wait_idle();
        rxq.delete();
        for (int i = 1; i <= 6; i++) store(TXA, 32'(i));
        chk("ovf_status", readdata, 32'h4D);
        wait_idle();
        chk("ovf_sticky", 32'(readdata[3]), 32'h1);
        chk("ovf_rx_n", rxq.size(), 5);
        for (int i = 0; i < 5 && i < rxq.size(); i++) chk("ovf_rx_byte", 32'(rxq[i]), 32'(i + 1));
        store(STA, 32'h8);
        chk("ovf_cleared", readdata, 32'h2);

        // Address decode
        memwrite = 1'b1;
        dataadr = 32'hFFFF_FF08;
        writedata = 32'h77;
        #1;
        chk("dec_ff08_iosel", 32'(io_sel), 32'h0);
        tick();
        dataadr = 32'h0000_0040;
        #1;
        chk("dec_40_iosel", 32'(io_sel), 32'h0);
        tick();
        memwrite = 1'b0;
        dataadr = STA;
        #1;
        chk("dec_no_push", readdata, 32'h2);
        tick();
        chk("dec_txd_idle", 32'(txd), 32'h1);
        dataadr = TXA;
        #1;
        chk("dec_load_iosel", 32'(io_sel), 32'h1);
        chk("dec_load_data", readdata, 32'h0);
        dataadr = STA;

        // Pointer wrap: 10 bytes, one at a time
        rxq.delete();
        exp_b.delete();
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            exp_b.push_back(b);
            store(TXA, {24'($urandom), b});
            wait_idle();
        end
        chk("wrap_rx_n", rxq.size(), 10);
        for (int i = 0; i < 10 && i < rxq.size(); i++) chk("wrap_rx_byte", 32'(rxq[i]), 32'(exp_b[i]));

        // Reset mid-frame
        store(TXA, 32'h3C);
        repeat (15) tick();
        reset = 1'b0;
        tick();
        chk("midrst_txd", 32'(txd), 32'h1);
        chk("midrst_status", readdata, 32'h2);
        reset = 1'b1;
        tick();
        chk("midrst_txd_after", 32'(txd), 32'h1);
        chk("midrst_status_after", readdata, 32'h2);

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            reset = (i == 700) ? 1'b0 : 1'b1;
            memwrite = 1'b0;
            dataadr = STA;
            writedata = $urandom;
            if (r < 35) begin
                memwrite = 1'b1;
                dataadr = TXA;
            end else if (r < 42) begin
                memwrite = 1'b1;
            end else if (r < 47) begin
                memwrite = 1'b1;
                dataadr = (r < 45) ? 32'hFFFF_FF08 : $urandom;
            end else if (r < 50) begin
                dataadr = TXA;
            end
            tick();
        end
        reset = 1'b1;
        wait_idle();
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
